// File: rtl/cl_mem_access.sv
// cl_mem_access
// Memory-access stage controller. Accepts one EX/MEM bundle at a time, runs
// at most one data-memory transaction for it and retires exactly one result
// to writeback per accepted instruction, in order.
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   req_*                    EX/MEM bundle in; req_ready_o stalls upstream
//   dmem_v_o .. dmem_mask_o  memory request, decoded from registered state
//   dmem_yumi_i              memory takes the request
//   dmem_v_i, dmem_data_i    read response
//   wb_*, misalign_o         registered one-cycle retire bundle
//   dbg_state                current FSM state (0 idle, 1 req, 2 wait)
//
// Handshakes:
//   upstream : a bundle transfers on a cycle where req_valid_i & req_ready_o.
//   request  : dmem_v_o stays high with stable fields until the cycle where
//              dmem_yumi_i is seen high; yumi outside that state is ignored.
//   response : dmem_v_i is only honoured while waiting for load data.
module cl_mem_access #(
  parameter int ADDR_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_is_load_i,
  input  logic                     req_is_store_i,
  input  logic                     req_is_byte_i,
  input  logic                     req_writes_rf_i,
  input  logic [ADDR_WIDTH-1:0]    req_alu_result_i,
  input  logic [31:0]              req_store_data_i,
  input  logic [RF_ADDR_WIDTH-1:0] req_rd_i,
  output logic                     dmem_v_o,
  output logic                     dmem_w_o,
  output logic [ADDR_WIDTH-1:0]    dmem_addr_o,
  output logic [31:0]              dmem_wdata_o,
  output logic [3:0]               dmem_mask_o,
  input  logic                     dmem_yumi_i,
  input  logic                     dmem_v_i,
  input  logic [31:0]              dmem_data_i,
  output logic                     wb_valid_o,
  output logic                     wb_writes_rf_o,
  output logic [RF_ADDR_WIDTH-1:0] wb_rd_o,
  output logic [31:0]              wb_data_o,
  output logic                     misalign_o,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Captured bundle for the outstanding memory op.
  logic                     r_is_store;
  logic                     r_is_byte;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [31:0]              r_sdata;
  logic [RF_ADDR_WIDTH-1:0] r_rd;

  logic accept;
  logic req_is_mem;
  logic req_misaligned;
  logic in_req;
  logic [7:0]  load_byte;
  logic [31:0] load_value;

  assign req_ready_o    = (state_q == IDLE);
  assign accept         = req_valid_i & req_ready_o;
  assign req_is_mem     = req_is_load_i | req_is_store_i;
  // Only word ops can be misaligned; byte ops may use any lane.
  assign req_misaligned = req_is_mem & ~req_is_byte_i &
                          (req_alu_result_i[1:0] != 2'b00);
  assign in_req         = (state_q == REQ);
  assign dbg_state      = state_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && req_is_mem && !req_misaligned) state_d = REQ;
      REQ:  if (dmem_yumi_i) state_d = r_is_store ? IDLE : WAIT;
      WAIT: if (dmem_v_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------- request outputs
  // Gated by the REQ state so everything reads zero when no request is up.
  always_comb begin
    dmem_v_o     = in_req;
    dmem_w_o     = in_req & r_is_store;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    dmem_mask_o  = 4'b0000;
    if (in_req) begin
      dmem_addr_o = {r_addr[ADDR_WIDTH-1:2], 2'b00};
      if (r_is_store) begin
        if (r_is_byte) begin
          dmem_mask_o  = 4'b0001 << r_addr[1:0];
          dmem_wdata_o = {4{r_sdata[7:0]}};
        end else begin
          dmem_mask_o  = 4'b1111;
          dmem_wdata_o = r_sdata;
        end
      end
    end
  end

  // ------------------------------------------------------ load formatting
  always_comb begin
    load_byte = dmem_data_i[7:0];
    case (r_addr[1:0])
      2'd0: load_byte = dmem_data_i[7:0];
      2'd1: load_byte = dmem_data_i[15:8];
      2'd2: load_byte = dmem_data_i[23:16];
      2'd3: load_byte = dmem_data_i[31:24];
      default: load_byte = dmem_data_i[7:0];
    endcase
    load_value = r_is_byte ? {24'd0, load_byte} : dmem_data_i;
  end

  // ------------------------------------------------------ bundle capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_is_store <= 1'b0;
      r_is_byte  <= 1'b0;
      r_addr     <= '0;
      r_sdata    <= '0;
      r_rd       <= '0;
    end else if (accept) begin
      r_is_store <= req_is_store_i;
      r_is_byte  <= req_is_byte_i;
      r_addr     <= req_alu_result_i;
      r_sdata    <= req_store_data_i;
      r_rd       <= req_rd_i;
    end
  end

  // ------------------------------------------------------ retire register
  // Every field defaults to zero so the bundle is a clean one-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_o     <= 1'b0;
      wb_writes_rf_o <= 1'b0;
      wb_rd_o        <= '0;
      wb_data_o      <= '0;
      misalign_o     <= 1'b0;
    end else begin
      wb_valid_o     <= 1'b0;
      wb_writes_rf_o <= 1'b0;
      wb_rd_o        <= '0;
      wb_data_o      <= '0;
      misalign_o     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && !req_is_mem) begin
            wb_valid_o     <= 1'b1;
            wb_writes_rf_o <= req_writes_rf_i;
            wb_rd_o        <= req_rd_i;
            wb_data_o      <= 32'(req_alu_result_i);
          end else if (accept && req_misaligned) begin
            wb_valid_o <= 1'b1;
            wb_rd_o    <= req_rd_i;
            misalign_o <= 1'b1;
          end
        end
        REQ: begin
          if (dmem_yumi_i && r_is_store) begin
            wb_valid_o <= 1'b1;
            wb_rd_o    <= r_rd;
          end
        end
        WAIT: begin
          if (dmem_v_i) begin
            wb_valid_o     <= 1'b1;
            wb_writes_rf_o <= 1'b1;
            wb_rd_o        <= r_rd;
            wb_data_o      <= load_value;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cl_mem_access.sv
module tb_cl_mem_access;

  // ------------------------------------------------------ clock and reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid_i = 0, req_is_load_i = 0, req_is_store_i = 0;
  logic        req_is_byte_i = 0, req_writes_rf_i = 0;
  logic [31:0] req_alu_result_i = 0, req_store_data_i = 0;
  logic [4:0]  req_rd_i = 0;
  logic        dmem_yumi_i = 0, dmem_v_i = 0;
  logic [31:0] dmem_data_i = 0;

  logic        req_ready_o, dmem_v_o, dmem_w_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_mask_o;
  logic        wb_valid_o, wb_writes_rf_o, misalign_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic [1:0]  dbg_state;

  cl_mem_access #(.ADDR_WIDTH(32), .RF_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_is_load_i(req_is_load_i), .req_is_store_i(req_is_store_i),
    .req_is_byte_i(req_is_byte_i), .req_writes_rf_i(req_writes_rf_i),
    .req_alu_result_i(req_alu_result_i), .req_store_data_i(req_store_data_i),
    .req_rd_i(req_rd_i),
    .dmem_v_o(dmem_v_o), .dmem_w_o(dmem_w_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_mask_o(dmem_mask_o),
    .dmem_yumi_i(dmem_yumi_i), .dmem_v_i(dmem_v_i), .dmem_data_i(dmem_data_i),
    .wb_valid_o(wb_valid_o), .wb_writes_rf_o(wb_writes_rf_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .misalign_o(misalign_o), .dbg_state(dbg_state)
  );

  int vectors = 0;
  int errors  = 0;

  // ------------------------------------------------------ scoreboard
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------ reference model
  // Memory-level view of an instruction: what the bus should see and what
  // writeback should get, computed from byte-address arithmetic.
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return a - (a % 4);
  endfunction

  function automatic logic [3:0] exp_mask(input bit is_byte, input logic [31:0] a);
    return is_byte ? 4'(1 << (a % 4)) : 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input bit is_byte, input logic [31:0] d);
    return is_byte ? (d % 256) * 32'h01010101 : d;
  endfunction

  function automatic logic [31:0] exp_load(input bit is_byte, input logic [31:0] a,
                                           input logic [31:0] w);
    return is_byte ? (w >> (8 * (a % 4))) % 256 : w;
  endfunction

  // ------------------------------------------------------ driver
  // Called at a sample point where the stage is idle. Leaves the bench at
  // the retire cycle, where the next accept may be driven.
  task automatic run_op(input bit ld, input bit st, input bit by, input bit wrf,
                        input logic [31:0] alu, input logic [31:0] sd,
                        input logic [4:0] rd, input int yumi_dly,
                        input int resp_dly, input logic [31:0] resp);
    bit mem = ld | st;
    bit mis = mem && !by && (alu % 4 != 0);
    check("ready_before_accept", 32'(req_ready_o), 1);
    req_valid_i = 1; req_is_load_i = ld; req_is_store_i = st;
    req_is_byte_i = by; req_writes_rf_i = wrf; req_alu_result_i = alu;
    req_store_data_i = sd; req_rd_i = rd;
    step();
    req_valid_i = 0;
    req_alu_result_i = $urandom; req_store_data_i = $urandom;
    if (!mem || mis) begin
      check("imm_wb_valid", 32'(wb_valid_o), 1);
      check("imm_misalign", 32'(misalign_o), 32'(mis));
      check("imm_dmem_v", 32'(dmem_v_o), 0);
      check("imm_ready", 32'(req_ready_o), 1);
      if (mis) check("mis_writes_rf", 32'(wb_writes_rf_o), 0);
      else begin
        check("alu_wb_data", wb_data_o, alu);
        check("alu_wb_rd", 32'(wb_rd_o), 32'(rd));
        check("alu_writes_rf", 32'(wb_writes_rf_o), 32'(wrf));
      end
      return;
    end
    for (int c = 0; c <= yumi_dly; c++) begin
      check("req_dmem_v", 32'(dmem_v_o), 1);
      check("req_dmem_w", 32'(dmem_w_o), 32'(st));
      check("req_addr", dmem_addr_o, word_addr(alu));
      check("req_mask", 32'(dmem_mask_o), st ? 32'(exp_mask(by, alu)) : 0);
      if (st) check("req_wdata", dmem_wdata_o, exp_wdata(by, sd));
      check("req_ready_low", 32'(req_ready_o), 0);
      check("req_no_wb", 32'(wb_valid_o), 0);
      if (c == yumi_dly) dmem_yumi_i = 1;
      dmem_v_i = $urandom_range(0, 1);   // ignored outside the wait state
      step();
      dmem_yumi_i = 0;
      dmem_v_i = 0;
    end
    if (st) begin
      check("st_wb_valid", 32'(wb_valid_o), 1);
      check("st_writes_rf", 32'(wb_writes_rf_o), 0);
      check("st_ready", 32'(req_ready_o), 1);
      return;
    end
    for (int c = 0; c <= resp_dly; c++) begin
      check("wait_dmem_v", 32'(dmem_v_o), 0);
      check("wait_no_wb", 32'(wb_valid_o), 0);
      check("wait_ready_low", 32'(req_ready_o), 0);
      dmem_yumi_i = $urandom_range(0, 1); // ignored outside the req state
      if (c == resp_dly) begin
        dmem_v_i = 1;
        dmem_data_i = resp;
      end else dmem_data_i = $urandom;
      step();
      dmem_v_i = 0;
      dmem_yumi_i = 0;
      dmem_data_i = $urandom;
    end
    check("ld_wb_valid", 32'(wb_valid_o), 1);
    check("ld_wb_data", wb_data_o, exp_load(by, alu, resp));
    check("ld_wb_rd", 32'(wb_rd_o), 32'(rd));
    check("ld_writes_rf", 32'(wb_writes_rf_o), 1);
    check("ld_ready", 32'(req_ready_o), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dmem_v"}, 32'(dmem_v_o), 0);
    check({tag, "_dmem_w"}, 32'(dmem_w_o), 0);
    check({tag, "_dmem_addr"}, dmem_addr_o, 0);
    check({tag, "_dmem_wdata"}, dmem_wdata_o, 0);
    check({tag, "_dmem_mask"}, 32'(dmem_mask_o), 0);
    check({tag, "_wb_valid"}, 32'(wb_valid_o), 0);
    check({tag, "_wb_writes_rf"}, 32'(wb_writes_rf_o), 0);
    check({tag, "_wb_rd"}, 32'(wb_rd_o), 0);
    check({tag, "_wb_data"}, wb_data_o, 0);
    check({tag, "_misalign"}, 32'(misalign_o), 0);
  endtask

  // ------------------------------------------------------ stimulus
  initial begin
    repeat (3) step();
    check_all_zero("reset");
    check("reset_ready", 32'(req_ready_o), 1);
    reset_n = 1;
    step();

    // Non-memory op, then pulse must drop the following cycle.
    run_op(0, 0, 0, 1, 32'h1234, 0, 5'd3, 0, 0, 0);
    step();
    check("alu_pulse_end", 32'(wb_valid_o), 0);
    check("alu_ready_kept", 32'(req_ready_o), 1);

    // SB to 0x102 with yumi held off 3 cycles.
    run_op(0, 1, 1, 0, 32'h102, 32'hAABBCC7E, 5'd0, 3, 0, 0);
    // LBU from 0x203, response two cycles after yumi.
    run_op(1, 0, 1, 1, 32'h203, 0, 5'd7, 0, 1, 32'h89ABCDEF);
    // LW from 0x40, yumi and response back-to-back.
    run_op(1, 0, 0, 1, 32'h40, 0, 5'd9, 0, 0, 32'hDEADBEEF);
    step();
    // Spurious response while idle must not retire anything.
    dmem_v_i = 1; dmem_data_i = 32'h55555555;
    step();
    dmem_v_i = 0;
    check("spurious_no_wb", 32'(wb_valid_o), 0);
    check("spurious_ready", 32'(req_ready_o), 1);
    // Misaligned LW.
    run_op(1, 0, 0, 1, 32'h41, 0, 5'd4, 0, 0, 0);

    // Back-to-back non-memory ops: one retire per cycle.
    for (int i = 0; i < 3; i++)
      run_op(0, 0, 0, 1'($urandom), $urandom, 0, 5'($urandom), 0, 0, 0);

    // Randomised mix.
    for (int i = 0; i < 40; i++) begin
      int kind = $urandom_range(0, 4);
      logic [31:0] a = $urandom;
      bit by = $urandom_range(0, 1);
      if (kind != 0 && !by && $urandom_range(0, 3) != 0) a = word_addr(a);
      run_op(kind == 1 || kind == 2, kind == 3 || kind == 4, by, 1'($urandom),
             a, $urandom, 5'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom);
    end

    // Reset while waiting for a load response.
    run_op(0, 0, 0, 0, 32'h0, 0, 5'd1, 0, 0, 0);
    req_valid_i = 1; req_is_load_i = 1; req_is_store_i = 0; req_is_byte_i = 0;
    req_alu_result_i = 32'h80; req_rd_i = 5'd6;
    step();
    req_valid_i = 0;
    dmem_yumi_i = 1;
    step();
    dmem_yumi_i = 0;
    check("pre_reset_wait", 32'(req_ready_o), 0);
    reset_n = 0;
    #1;
    check_all_zero("midreset");
    check("midreset_ready", 32'(req_ready_o), 1);
    step();
    reset_n = 1;
    step();
    check("post_reset_ready", 32'(req_ready_o), 1);
    dmem_v_i = 1; dmem_data_i = 32'h12345678;
    step();
    dmem_v_i = 0;
    check("late_resp_no_wb", 32'(wb_valid_o), 0);
    check("late_resp_no_req", 32'(dmem_v_o), 0);
    check("late_resp_ready", 32'(req_ready_o), 1);
    step();
    check_all_zero("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cl_mem_access.md
# cl_mem_access

Memory-access stage controller for the pipelined core. It sits directly downstream of the decode/controller and EX stage: it takes the registered EX/MEM bundle (load/store/byte flags, ALU result, store data, destination register), runs one data-memory transaction per memory instruction through a valid/yumi request handshake and a response-valid return, formats byte loads and stores, and presents one retired result per instruction to writeback. Upstream is stalled with `req_ready_o` while a transaction is outstanding.

## Interface
- `ADDR_WIDTH`, default 32: byte address width.
- `RF_ADDR_WIDTH`, default 5: destination register index width.
- Data path is fixed at 32 bits (4 byte lanes).

- `clk` input 1: the single clock.
- `reset_n` input 1: reset, asynchronous and active-low.
- `req_valid_i` input 1: EX/MEM bundle valid.
- `req_ready_o` output 1: stage accepts the bundle this cycle.
- `req_is_load_i`, `req_is_store_i`, `req_is_byte_i` input 1 each: op class from decode (LW/LBU, SW/SB, byte variant).
- `req_writes_rf_i` input 1: instruction writes the register file.
- `req_alu_result_i` input ADDR_WIDTH: ALU result; the effective address for memory ops.
- `req_store_data_i` input 32: rt value for stores.
- `req_rd_i` input RF_ADDR_WIDTH: destination register.
- `dmem_v_o` output 1: memory request valid.
- `dmem_w_o` output 1: request is a write.
- `dmem_addr_o` output ADDR_WIDTH: word-aligned request address.
- `dmem_wdata_o` output 32: write data.
- `dmem_mask_o` output 4: byte-lane write enables.
- `dmem_yumi_i` input 1: memory accepts the request this cycle.
- `dmem_v_i` input 1: read response valid.
- `dmem_data_i` input 32: read response word.
- `wb_valid_o` output 1: one-cycle retire pulse.
- `wb_writes_rf_o` output 1: retired instruction writes the register file.
- `wb_rd_o` output RF_ADDR_WIDTH: destination register.
- `wb_data_o` output 32: writeback value.
- `misalign_o` output 1: retired instruction was a misaligned word access.

## Operation
- FSM states: IDLE, REQ, WAIT. `req_ready_o` = (state == IDLE).
- Accept = `req_valid_i & req_ready_o`. On accept, all request fields are captured into internal registers.
- Non-memory op accepted: stay in IDLE. Next cycle `wb_valid_o`=1, `wb_data_o`=ALU result, and `wb_writes_rf_o`/`wb_rd_o` are taken from the request.
- Word op with `alu_result[1:0]` ≠ 0: no memory request is issued. Next cycle `wb_valid_o`=1, `misalign_o`=1, `wb_writes_rf_o`=0. Stay in IDLE.
- Any other memory op accepted: go to REQ.
- REQ:
  - `dmem_v_o`=1; `dmem_addr_o` = {addr[ADDR_WIDTH-1:2], 2'b00}; `dmem_w_o` = is_store.
  - SW: `dmem_mask_o`=4'b1111, wdata = store data.
  - SB: `dmem_mask_o` = 4'b0001 << addr[1:0], wdata = store byte replicated into all 4 lanes.
  - Loads: `dmem_mask_o`=0.
  - All request outputs hold stable until `dmem_yumi_i`.
  - On yumi: store goes to IDLE and retires next cycle (`wb_writes_rf_o`=0); load goes to WAIT.
- WAIT:
  - On `dmem_v_i` (including the cycle right after yumi), go to IDLE and retire next cycle with `wb_writes_rf_o`=1.
  - LW: `wb_data_o` = `dmem_data_i`.
  - LBU: `wb_data_o` = zero-extended byte from lane addr[1:0] (lane 0 = bits 7:0, little-endian).
- `dmem_v_i` outside WAIT is ignored. `dmem_yumi_i` outside REQ is ignored.
- Exactly one `wb_valid_o` pulse per accepted instruction, in program order.

## Timing
- Reset: state=IDLE. `req_ready_o`=1. `dmem_v_o`, `dmem_w_o`, `dmem_mask_o`, `dmem_addr_o`, `dmem_wdata_o`, all `wb_*` outputs and `misalign_o` = 0.
- Reset mid-transaction aborts it with no retire. A late `dmem_v_i` after reset is ignored.
- All `wb_*` outputs and `misalign_o` are registered. They are valid for exactly one cycle, then return to 0.
- `dmem_*` request outputs are decoded from registered state only, with no combinational path from `dmem_yumi_i`.
- Latencies (accept at cycle 0):
  - Non-memory or misaligned: retire at cycle 1; the next accept can occur at cycle 1.
  - Memory op: `dmem_v_o` at cycle 1. If yumi arrives at cycle k, a store retires at k+1. If the response arrives at cycle m > k, a load retires at m+1.
- `req_ready_o` drops at cycle 1 for memory ops and returns in the cycle of retirement.
- Back-to-back non-memory ops sustain one retire per cycle.

## Test plan
- Non-memory op (ALU result 0x1234, rd=3, writes_rf=1) -> `wb_valid_o` for 1 cycle at cycle 1, `wb_data_o`=0x1234, `wb_rd_o`=3, `req_ready_o` never drops.
- SB, addr 0x102, data 0xAABBCC7E, yumi held off 3 cycles -> `dmem_v_o` steady with addr 0x100, mask 4'b0100, wdata 0x7E7E7E7E; retire one cycle after yumi with `wb_writes_rf_o`=0.
- LBU, addr 0x203, response 0x89ABCDEF arriving 2 cycles after yumi -> `wb_data_o`=0x00000089, one cycle after `dmem_v_i`.
- LW, addr 0x40, yumi and response back-to-back -> `wb_data_o` = response word; spurious `dmem_v_i` while IDLE produces no retire.
- LW, addr 0x41 -> no `dmem_v_o`; retire at cycle 1 with `misalign_o`=1, `wb_writes_rf_o`=0.
- `reset_n` asserted while in WAIT -> all outputs 0 immediately; after release `req_ready_o`=1 and a late `dmem_v_i` is ignored.
